// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: widths, reset PC, fetch entry layout.
// Used by the prefetch unit, its queue and its bus interface.
package rv32i_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_BITS = $bits(fetch_entry_t);

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Bundle of control, memory request/response and IF/ID queue signals.
// master = prefetch unit side, slave = pipeline/memory environment side.
interface fetch_prefetch_unit_if;
  import rv32i_pkg::*;

  logic            enable;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;

  logic            resp_valid;
  logic [XLEN-1:0] resp_data;

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;

  logic            busy;

  modport master (
    input  enable, redirect, redirect_target,
    input  req_ready, resp_valid, resp_data, out_ready,
    output req_valid, req_addr, out_valid, out_pc, out_instr, busy
  );

  modport slave (
    output enable, redirect, redirect_target,
    output req_ready, resp_valid, resp_data, out_ready,
    input  req_valid, req_addr, out_valid, out_pc, out_instr, busy
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous circular queue with a combinational read port.
// clear wins over push/pop; storage is zeroed only on reset.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// RV32I instruction-fetch front end: sequential word prefetch into a small
// {pc, instr} queue, with flush and stale-response dropping on redirect.
module fetch_prefetch_unit
  import rv32i_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_prefetch_unit_if.master  bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_drop_cnt;
  logic            r_run;

  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic            w_full;
  fetch_entry_t    w_din;
  fetch_entry_t    w_dout;
  logic            w_resp;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_room;
  logic            w_below_max;
  int              w_reserved;

  // Slots already promised to stored entries plus kept in-flight words.
  always_comb begin
    w_reserved  = int'(w_count) + int'(r_outstanding) - int'(r_drop_cnt);
    w_room      = (w_reserved < DEPTH);
    w_below_max = (int'(r_outstanding) < MAX_OUTSTANDING);
  end

  assign w_resp   = bus.resp_valid & (r_outstanding != '0);
  assign w_accept = bus.req_valid & bus.req_ready;
  assign w_push   = w_resp & ~bus.redirect & (r_drop_cnt == '0);
  assign w_pop    = ~w_empty & bus.out_ready & bus.enable & ~bus.redirect;
  assign w_din    = '{pc: r_resp_pc, instr: bus.resp_data};

  assign bus.req_valid = r_run & bus.enable & ~bus.redirect & w_below_max & w_room;
  assign bus.req_addr  = r_fetch_pc;
  assign bus.out_valid = ~w_empty;
  assign bus.out_pc    = w_dout.pc;
  assign bus.out_instr = w_dout.instr;
  assign bus.busy      = (r_outstanding != '0) | (r_drop_cnt != '0);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (bus.redirect),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_run         <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case ({w_accept, w_resp})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      // Every word still in flight after this edge belongs to the old stream.
      if (bus.redirect) begin
        r_fetch_pc <= align_word(bus.redirect_target);
        r_resp_pc  <= align_word(bus.redirect_target);
        r_drop_cnt <= r_outstanding - OW'(w_resp);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
        if (w_resp) begin
          if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - OW'(1);
          else                  r_resp_pc  <= r_resp_pc + XLEN'(INSTR_BYTES);
        end
      end
    end
  end

  logic w_unused;
  assign w_unused = w_full;

endmodule
